// File: rtl/checkers_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : checkers_pkg
//  Description : Shared types and helpers for the checkers move generator.
//                Direction encoding, FSM state encoding, default board edge
//                length and a helper giving the playable-square count.
//  Revision    : 1.0  initial release
// ============================================================================
package checkers_pkg;

    // Default board edge length (standard 8x8 checkers board).
    localparam int c_default_side = 8;

    // Direction order used by the sweep: down-left, down-right, up-left,
    // up-right. Bit 1 set means "toward row 0".
    typedef enum logic [1:0] {
        DIR_DL = 2'd0,
        DIR_DR = 2'd1,
        DIR_UL = 2'd2,
        DIR_UR = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of playable (dark) squares on a SIDE x SIDE board.
    function automatic int squares(input int side);
        return (side * side) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/diag_shift.sv
`default_nettype none
// ============================================================================
//  Module      : diag_shift
//  Description : Generic diagonal neighbour gather. For every playable square
//                i, nb[i] = x[neighbour_dir(i)], or 0 when the neighbour lies
//                off the board. Purely combinational.
//  Ports       : x   [N] in  - source bitboard
//                dir [2] in  - direction (DL, DR, UL, UR)
//                nb  [N] out - bitboard gathered from the diagonal neighbour
//  Revision    : 1.0  initial release
// ============================================================================
module diag_shift
    import checkers_pkg::*;
#(
    parameter int SIDE = c_default_side
) (
    input  logic [squares(SIDE)-1:0] x,
    input  logic [1:0]               dir,
    output logic [squares(SIDE)-1:0] nb
);

    localparam int c_h = SIDE / 2;
    localparam int c_n = squares(SIDE);

    for (genvar g = 0; g < c_n; g++) begin : g_sq
        localparam int c_r    = g / c_h;
        localparam int c_c    = g % c_h;
        localparam bit c_even = ((c_r % 2) == 0);

        // Existence of each neighbour; index is clamped to 0 when absent so
        // that the constant select always stays in range.
        localparam bit c_has_dl = (c_r <= SIDE - 2) && (!c_even || (c_c >= 1));
        localparam bit c_has_dr = (c_r <= SIDE - 2) && ( c_even || (c_c <= c_h - 2));
        localparam bit c_has_ul = (c_r >= 1)        && (!c_even || (c_c >= 1));
        localparam bit c_has_ur = (c_r >= 1)        && ( c_even || (c_c <= c_h - 2));

        localparam int c_nb_dl = !c_has_dl ? 0 : (c_even ? g + c_h - 1 : g + c_h);
        localparam int c_nb_dr = !c_has_dr ? 0 : (c_even ? g + c_h     : g + c_h + 1);
        localparam int c_nb_ul = !c_has_ul ? 0 : (c_even ? g - c_h - 1 : g - c_h);
        localparam int c_nb_ur = !c_has_ur ? 0 : (c_even ? g - c_h     : g - c_h + 1);

        logic [3:0] w_cand;

        assign w_cand[DIR_DL] = c_has_dl ? x[c_nb_dl] : 1'b0;
        assign w_cand[DIR_DR] = c_has_dr ? x[c_nb_dr] : 1'b0;
        assign w_cand[DIR_UL] = c_has_ul ? x[c_nb_ul] : 1'b0;
        assign w_cand[DIR_UR] = c_has_ur ? x[c_nb_ur] : 1'b0;

        assign nb[g] = w_cand[dir];
    end

endmodule
`default_nettype wire

// File: rtl/move_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : move_mask_gen
//  Description : Sequential diagonal-move mask generator. Latches a board
//                snapshot on start, sweeps DL, DR, UL, UR one per clock and
//                reports which own squares have a legal slide and which have
//                a legal single jump.
//  Ports       : clock, reset (sync, active-high), start
//                own, opp, kings [N] in, side in
//                busy, done, slide_mask [N], jump_mask [N], any_jump out
//  Options     : MOVE_MASK_FORCED_CAPTURE_EN - when defined, slide_mask is
//                forced to zero whenever any jump exists (compulsory capture).
//  Revision    : 1.0  initial release
// ============================================================================
module move_mask_gen
    import checkers_pkg::*;
#(
    parameter int SIDE = c_default_side
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [squares(SIDE)-1:0] own,
    input  logic [squares(SIDE)-1:0] opp,
    input  logic [squares(SIDE)-1:0] kings,
    input  logic                     side,
    output logic                     busy,
    output logic                     done,
    output logic [squares(SIDE)-1:0] slide_mask,
    output logic [squares(SIDE)-1:0] jump_mask,
    output logic                     any_jump
);

    localparam int c_n = squares(SIDE);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [1:0]     r_dir;
    logic [c_n-1:0] r_own;
    logic [c_n-1:0] r_opp;
    logic [c_n-1:0] r_kings;
    logic           r_side;
    logic [c_n-1:0] r_slide_acc;
    logic [c_n-1:0] r_jump_acc;
    logic           r_busy;
    logic           r_done;
    logic [c_n-1:0] r_slide_mask;
    logic [c_n-1:0] r_jump_mask;
    logic           r_any_jump;

    logic [c_n-1:0] w_empty;
    logic [c_n-1:0] w_nb_empty;
    logic [c_n-1:0] w_opp_then_empty;
    logic [c_n-1:0] w_nb_jump;
    logic           w_fwd;
    logic [c_n-1:0] w_elig;
    logic           w_accept;
    logic [c_n-1:0] w_slide_final;

    assign w_empty = ~(r_own | r_opp);

    // A jump in direction d needs nb_d(opp) & nb_d(nb_d(empty)). Because the
    // gather is bitwise, that equals nb_d(opp & nb_d(empty)), so a second
    // shifter over the pre-masked vector covers both terms.
    assign w_opp_then_empty = r_opp & w_nb_empty;

    diag_shift #(.SIDE(SIDE)) u_shift_empty (
        .x   (w_empty),
        .dir (r_dir),
        .nb  (w_nb_empty)
    );

    diag_shift #(.SIDE(SIDE)) u_shift_jump (
        .x   (w_opp_then_empty),
        .dir (r_dir),
        .nb  (w_nb_jump)
    );

    // Down directions have dir[1]=0; they are forward when side=0.
    assign w_fwd  = (r_dir[1] == r_side);
    assign w_elig = w_fwd ? r_own : (r_own & r_kings);

    // busy stays high through the done cycle, while the state is already
    // IDLE; gating on it keeps a start in that cycle from being taken.
    assign w_accept = (r_state == ST_IDLE) && !r_busy && start;

`ifdef MOVE_MASK_FORCED_CAPTURE_EN
    assign w_slide_final = (|r_jump_acc) ? '0 : r_slide_acc;
`else
    assign w_slide_final = r_slide_acc;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)      w_state_nxt = ST_SCAN;
            ST_SCAN: if (r_dir == 2'd3) w_state_nxt = ST_DONE;
            ST_DONE:                    w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dir        <= 2'd0;
            r_own        <= '0;
            r_opp        <= '0;
            r_kings      <= '0;
            r_side       <= 1'b0;
            r_slide_acc  <= '0;
            r_jump_acc   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_slide_mask <= '0;
            r_jump_mask  <= '0;
            r_any_jump   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (r_state != ST_IDLE);
            r_done  <= (r_state == ST_DONE);

            if (w_accept) begin
                r_own        <= own;
                r_opp        <= opp;
                r_kings      <= kings;
                r_side       <= side;
                r_slide_acc  <= '0;
                r_jump_acc   <= '0;
                r_dir        <= 2'd0;
                r_slide_mask <= '0;
                r_jump_mask  <= '0;
                r_any_jump   <= 1'b0;
            end

            if (r_state == ST_SCAN) begin
                r_slide_acc <= r_slide_acc | (w_elig & w_nb_empty);
                r_jump_acc  <= r_jump_acc  | (w_elig & w_nb_jump);
                r_dir       <= r_dir + 2'd1;
            end

            if (r_state == ST_DONE) begin
                r_slide_mask <= w_slide_final;
                r_jump_mask  <= r_jump_acc;
                r_any_jump   <= |r_jump_acc;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign slide_mask = r_slide_mask;
    assign jump_mask  = r_jump_mask;
    assign any_jump   = r_any_jump;

endmodule
`default_nettype wire

// File: tb/tb_move_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_mask_gen
//  Description : Self-checking bench for move_mask_gen (SIDE=8). Reference
//                masks come from a row/column board model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_move_mask_gen;

    localparam int c_side = 8;
    localparam int c_h    = c_side / 2;
    localparam int c_n    = c_side * c_side / 2;

    logic           clock;
    logic           reset;
    logic           start;
    logic [c_n-1:0] own;
    logic [c_n-1:0] opp;
    logic [c_n-1:0] kings;
    logic           side;
    logic           busy;
    logic           done;
    logic [c_n-1:0] slide_mask;
    logic [c_n-1:0] jump_mask;
    logic           any_jump;

    int n_vec;
    int n_err;

    move_mask_gen #(.SIDE(c_side)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .own        (own),
        .opp        (opp),
        .kings      (kings),
        .side       (side),
        .busy       (busy),
        .done       (done),
        .slide_mask (slide_mask),
        .jump_mask  (jump_mask),
        .any_jump   (any_jump)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Neighbour by physical coordinates: square i sits at row r, column
    // 2c + (r odd). Returns -1 when the target is off the board.
    function automatic int nbr(input int i, input int d);
        int r, col, nr, nc;
        r   = i / c_h;
        col = 2 * (i % c_h) + (r % 2);
        nr  = r   + ((d < 2) ? 1 : -1);
        nc  = col + ((d == 0 || d == 2) ? -1 : 1);
        if (nr < 0 || nr >= c_side || nc < 0 || nc >= c_side) return -1;
        return nr * c_h + nc / 2;
    endfunction

    task automatic ref_masks(input logic [c_n-1:0] o, input logic [c_n-1:0] p,
                             input logic [c_n-1:0] k, input logic s,
                             output logic [c_n-1:0] es, output logic [c_n-1:0] ej);
        logic [c_n-1:0] emp;
        int n, m;
        bit fwd;
        emp = ~(o | p);
        es  = '0;
        ej  = '0;
        for (int i = 0; i < c_n; i++) begin
            if (o[i]) begin
                for (int d = 0; d < 4; d++) begin
                    fwd = (s == 1'b0) ? (d < 2) : (d >= 2);
                    if (fwd || k[i]) begin
                        n = nbr(i, d);
                        if (n >= 0) begin
                            if (emp[n]) es[i] = 1'b1;
                            if (p[n]) begin
                                m = nbr(n, d);
                                if (m >= 0 && emp[m]) ej[i] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
`ifdef MOVE_MASK_FORCED_CAPTURE_EN
        if (ej != '0) es = '0;
`endif
    endtask

    // One full sweep with cycle-by-cycle checks of the handshake.
    task automatic run_sweep(input string name,
                             input logic [c_n-1:0] o, input logic [c_n-1:0] p,
                             input logic [c_n-1:0] k, input logic s,
                             input logic [c_n-1:0] es, input logic [c_n-1:0] ej,
                             input bit scramble);
        @(negedge clock);
        own = o; opp = p; kings = k; side = s; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n_vec++;
        if (slide_mask !== '0 || jump_mask !== '0 || any_jump !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s clear_on_start: slide=%h jump=%h any=%b done=%b, want 0", name, slide_mask, jump_mask, any_jump, done);
        end
        if (scramble) begin
            own = $urandom; opp = $urandom; kings = $urandom; side = ~s;
        end
        for (int j = 1; j <= 4; j++) begin
            @(posedge clock); #1;
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s scan_cycle%0d: busy=%b done=%b, want busy=1 done=0", name, j, busy, done);
            end
        end
        @(posedge clock); #1;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b1 || slide_mask !== es || jump_mask !== ej
            || any_jump !== (ej != '0)) begin
            n_err++;
            $display("FAIL %s result: done=%b busy=%b slide=%h jump=%h any=%b, want done=1 busy=1 slide=%h jump=%h any=%b",
                     name, done, busy, slide_mask, jump_mask, any_jump, es, ej, (ej != '0));
        end
        @(posedge clock); #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || slide_mask !== es || jump_mask !== ej) begin
            n_err++;
            $display("FAIL %s hold: done=%b busy=%b slide=%h jump=%h, want done=0 busy=0 slide=%h jump=%h",
                     name, done, busy, slide_mask, jump_mask, es, ej);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; own = '0; opp = '0; kings = '0; side = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || slide_mask !== '0 || jump_mask !== '0 || any_jump !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b slide=%h jump=%h any=%b, want all 0", busy, done, slide_mask, jump_mask, any_jump);
        end
    endtask

    task automatic test_directed();
        logic [c_n-1:0] jump_slide;
`ifdef MOVE_MASK_FORCED_CAPTURE_EN
        jump_slide = 32'h0000_0000;
`else
        jump_slide = 32'h0000_0200;
`endif
        run_sweep("plain_slide", 32'h0000_0200, 32'h0, 32'h0, 1'b0, 32'h0000_0200, 32'h0, 1'b0);
        run_sweep("jump",        32'h0000_0200, 32'h0000_2000, 32'h0, 1'b0, jump_slide, 32'h0000_0200, 1'b0);
        run_sweep("edge_block",  32'h0000_0100, 32'h0002_1000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        run_sweep("up_man",      32'h1000_0000, 32'h0, 32'h0, 1'b1, 32'h1000_0000, 32'h0, 1'b0);
        run_sweep("back_man",    32'h1000_0000, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        run_sweep("back_king",   32'h1000_0000, 32'h0, 32'h1000_0000, 1'b0, 32'h1000_0000, 32'h0, 1'b0);
        run_sweep("empty_own",   32'h0, 32'hFFFF_0000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [c_n-1:0] o, p, k, es, ej;
        logic s;
        for (int t = 0; t < 40; t++) begin
            o = $urandom & $urandom;
            p = ($urandom & $urandom) & ~o;
            k = $urandom;
            s = 1'($urandom_range(0, 1));
            ref_masks(o, p, k, s, es, ej);
            // Odd iterations also change the inputs mid-sweep.
            run_sweep("random", o, p, k, s, es, ej, (t % 2) == 1);
        end
    endtask

    task automatic test_start_held();
        int last_acc;
        bit exp_done;
        last_acc = -100;
        @(negedge clock);
        own = 32'h0000_0200; opp = '0; kings = '0; side = 1'b0; start = 1'b1;
        for (int e = 0; e < 22; e++) begin
            // Edge e: a start held during edges 0..9 is taken only once the
            // previous sweep (accept edge + 6 more edges) has fully ended.
            if (e < 10 && (e - last_acc) >= 7) last_acc = e;
            exp_done = (e == last_acc + 5) || (e == 12 && last_acc == 7);
            @(posedge clock); #1;
            if (e == 9) start = 1'b0;
            n_vec++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL start_held edge%0d: done=%b, want %b", e, done, exp_done);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        own = 32'h0000_0200; opp = '0; kings = '0; side = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || slide_mask !== '0 || jump_mask !== '0 || any_jump !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b slide=%h jump=%h any=%b, want all 0", busy, done, slide_mask, jump_mask, any_jump);
        end
        for (int j = 0; j < 6; j++) begin
            @(posedge clock); #1;
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_quiet%0d: done=%b busy=%b, want 0", j, done, busy);
            end
        end
        run_sweep("after_reset", 32'h0000_0200, 32'h0, 32'h0, 1'b0, 32'h0000_0200, 32'h0, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
